// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: sizes, FSM state type, FK/CK constants, S-box and L transform.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package sm4_pkg;

   localparam int SM4_ROUNDS = 32;
   localparam int SM4_WORD   = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // System parameter FK, XORed into the user key at the start of key expansion.
   localparam logic [0:3][31:0] FK = {32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};

   // CK[i] byte j is (4*i + j) * 7 mod 256, most significant byte first.
   function automatic logic [0:31][31:0] sm4_gen_ck();
      logic [0:31][31:0] ck;
      ck = '0;
      for (int i = 0; i < 32; i++) begin
         for (int j = 0; j < 4; j++) begin
            ck[i][31 - 8*j -: 8] = 8'((4*i + j) * 7);
         end
      end
      return ck;
   endfunction

   localparam logic [0:31][31:0] CK = sm4_gen_ck();

   // Entry 0 sits in the most significant byte, so SBOX[a] is the S-box output for a.
   localparam logic [0:255][7:0] SBOX = {
      128'hd690e9fecce13db716b614c228fb2c05,
      128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62,
      128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8,
      128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887,
      128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1,
      128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f,
      128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8,
      128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684,
      128'h18f07dec3adc4d2079ee5f3ed7cb3948
   };

   function automatic logic [7:0] sm4_sbox(input logic [7:0] a);
      return SBOX[a];
   endfunction

   // Data-path linear transform: B ^ B<<<2 ^ B<<<10 ^ B<<<18 ^ B<<<24.
   function automatic logic [31:0] sm4_l(input logic [31:0] b);
      return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
               ^ {b[13:0], b[31:14]} ^ {b[7:0],  b[31:8]};
   endfunction

endpackage

// File: rtl/sm4_t_func.sv
// SM4 round T function: four S-box byte lanes (tau) followed by the L transform.
// Latency: combinational.  Ports: t_in (32b) -> t_out (32b).
// Backpressure: not applicable.
module sm4_t_func
   import sm4_pkg::*;
(
   input  logic [SM4_WORD-1:0] t_in,
   output logic [SM4_WORD-1:0] t_out
);

   logic [SM4_WORD-1:0] tau;

   for (genvar i = 0; i < 4; i++) begin : g_lane
      assign tau[8*i +: 8] = sm4_sbox(t_in[8*i +: 8]);
   end

   assign t_out = sm4_l(tau);

endmodule

// File: rtl/sm4_round_engine.sv
// Iterative SM4 cipher, one round per clock; DECRYPT walks round keys 31..0, else 0..31.
// Latency: accept edge E -> out_valid from E+32; accepts a new block only from IDLE.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE.
// Ports: in_valid/in_ready/data_in block input, rk_addr/rk_data combinational key-store
// read, out_valid/out_ready/data_out registered result, busy high while rounds run.
module sm4_round_engine
   import sm4_pkg::*;
#(
   parameter bit DECRYPT = 1'b1,
   parameter int ROUNDS  = SM4_ROUNDS   // only 32 is a valid SM4 configuration
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [127:0]                data_in,
   output logic [$clog2(ROUNDS)-1:0]   rk_addr,
   input  logic [SM4_WORD-1:0]         rk_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [127:0]                data_out,
   output logic                        busy
);

   localparam int            CW   = $clog2(ROUNDS);
   localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [127:0]    x_q, x_d;        // {X0,X1,X2,X3}, X0 in the top word
   logic [127:0]    data_out_q, data_out_d;
   logic            out_valid_q, out_valid_d;
   logic            in_ready_q, in_ready_d;
   logic            busy_q, busy_d;

   logic [SM4_WORD-1:0] t_in, t_out, x_new;

   assign t_in  = x_q[95:64] ^ x_q[63:32] ^ x_q[31:0] ^ rk_data;
   assign x_new = x_q[127:96] ^ t_out;

   sm4_t_func u_t_func (
      .t_in  (t_in),
      .t_out (t_out)
   );

   // cnt is cleared on leaving RUN, so outside RUN this already points at the
   // first key of the next block.
   assign rk_addr = DECRYPT ? (LAST - cnt_q) : cnt_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      x_d         = x_q;
      data_out_d  = data_out_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               x_d     = data_in;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            x_d = {x_q[95:0], x_new};
            if (cnt_q == LAST) begin
               // Output is the reversed final state {X35,X34,X33,X32}.
               data_out_d  = {x_new, x_q[31:0], x_q[63:32], x_q[95:64]};
               out_valid_d = 1'b1;
               cnt_d       = '0;
               state_d     = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d = (state_d == IDLE);
      busy_d     = (state_d == RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         x_q         <= '0;
         data_out_q  <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         x_q         <= x_d;
         data_out_q  <= data_out_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign data_out  = data_out_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_sm4_round_engine.sv
// Directed bench for sm4_round_engine: one decrypt and one encrypt instance sharing a
// key store expanded from the standard SM4 test key.
// Checks reset, latency, key order, back-pressure, back-to-back, abort and ignore cases.
module tb_sm4_round_engine;
   import sm4_pkg::*;

   localparam logic [127:0] KEY = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] PT  = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] CT  = 128'h681edf34d206965e86b3e94f536e4246;
   localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         in_valid_d, in_ready_d, out_valid_d, out_ready_d, busy_d;
   logic [127:0] data_in_d, data_out_d;
   logic [4:0]   rk_addr_d;
   logic [31:0]  rk_data_d;

   logic         in_valid_e, in_ready_e, out_valid_e, out_ready_e, busy_e;
   logic [127:0] data_in_e, data_out_e;
   logic [4:0]   rk_addr_e;
   logic [31:0]  rk_data_e;

   logic [31:0]  rk_mem [32];
   assign rk_data_d = rk_mem[rk_addr_d];
   assign rk_data_e = rk_mem[rk_addr_e];

   sm4_round_engine #(.DECRYPT(1'b1), .ROUNDS(32)) dut_dec (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_d), .in_ready(in_ready_d),
      .data_in(data_in_d), .rk_addr(rk_addr_d), .rk_data(rk_data_d),
      .out_valid(out_valid_d), .out_ready(out_ready_d), .data_out(data_out_d), .busy(busy_d)
   );

   sm4_round_engine #(.DECRYPT(1'b0), .ROUNDS(32)) dut_enc (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_e), .in_ready(in_ready_e),
      .data_in(data_in_e), .rk_addr(rk_addr_e), .rk_data(rk_data_e),
      .out_valid(out_valid_e), .out_ready(out_ready_e), .data_out(data_out_e), .busy(busy_e)
   );

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Key-expansion T' transform: S-box lanes then B ^ B<<<13 ^ B<<<23.
   function automatic logic [31:0] t_prime(input logic [31:0] x);
      logic [31:0] b;
      for (int i = 0; i < 4; i++) b[8*i +: 8] = sm4_sbox(x[8*i +: 8]);
      return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
   endfunction

   task automatic expand_key(input logic [127:0] mk);
      logic [31:0] k0, k1, k2, k3, kn;
      k0 = mk[127:96] ^ FK[0];
      k1 = mk[95:64]  ^ FK[1];
      k2 = mk[63:32]  ^ FK[2];
      k3 = mk[31:0]   ^ FK[3];
      for (int i = 0; i < 32; i++) begin
         kn = k0 ^ t_prime(k1 ^ k2 ^ k3 ^ CK[i]);
         rk_mem[i] = kn;
         k0 = k1; k1 = k2; k2 = k3; k3 = kn;
      end
   endtask

   logic [127:0] c2;
   int           hits;

   initial begin
      in_valid_d = 1'b0; out_ready_d = 1'b0; data_in_d = '0;
      in_valid_e = 1'b0; out_ready_e = 1'b0; data_in_e = '0;
      expand_key(KEY);

      // Reset state
      tick(); tick();
      chk("rk0_expanded", rk_mem[0], 128'hf12186f9);
      chk("rk31_expanded", rk_mem[31], 128'h9124a012);
      chk("rst_in_ready", in_ready_d, 0);
      chk("rst_out_valid", out_valid_d, 0);
      chk("rst_data_out", data_out_d, 0);
      chk("rst_busy", busy_d, 0);
      chk("rst_rk_addr_dec", rk_addr_d, 31);
      chk("rst_rk_addr_enc", rk_addr_e, 0);
      rst_n = 1'b1;
      tick();
      chk("idle_in_ready_dec", in_ready_d, 1);
      chk("idle_in_ready_enc", in_ready_e, 1);

      // Standard decrypt vector, latency and key order
      in_valid_d = 1'b1; data_in_d = CT;
      tick();
      in_valid_d = 1'b0;
      chk("dec_busy_after_accept", busy_d, 1);
      chk("dec_in_ready_run", in_ready_d, 0);
      chk("dec_rk_addr_r0", rk_addr_d, 31);
      for (int k = 1; k <= 31; k++) begin
         tick();
         chk("dec_rk_addr", rk_addr_d, 128'(31 - k));
         chk("dec_out_valid_early", out_valid_d, 0);
      end
      tick();
      chk("dec_out_valid_e32", out_valid_d, 1);
      chk("dec_data_out", data_out_d, PT);
      chk("dec_busy_done", busy_d, 0);
      chk("dec_rk_addr_done", rk_addr_d, 31);

      // Back-pressure: result held for 10 cycles
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("bp_out_valid", out_valid_d, 1);
         chk("bp_data_out", data_out_d, PT);
         chk("bp_in_ready", in_ready_d, 0);
      end
      out_ready_d = 1'b1;
      tick();
      out_ready_d = 1'b0;
      chk("bp_release_out_valid", out_valid_d, 0);
      chk("bp_release_in_ready", in_ready_d, 1);

      // Encrypt vector and ascending key order
      in_valid_e = 1'b1; data_in_e = PT;
      tick();
      in_valid_e = 1'b0;
      chk("enc_busy", busy_e, 1);
      chk("enc_rk_addr_r0", rk_addr_e, 0);
      for (int k = 1; k <= 31; k++) begin
         tick();
         chk("enc_rk_addr", rk_addr_e, 128'(k));
      end
      tick();
      chk("enc_out_valid", out_valid_e, 1);
      chk("enc_data_out", data_out_e, CT);
      chk("enc_rk_addr_done", rk_addr_e, 0);
      out_ready_e = 1'b1;
      tick();
      chk("enc_release_in_ready", in_ready_e, 1);

      // out_ready already high when out_valid rises: IDLE at E+33
      in_valid_e = 1'b1; data_in_e = PT2;
      tick();
      in_valid_e = 1'b0;
      repeat (31) tick();
      chk("enc2_out_valid_early", out_valid_e, 0);
      tick();
      chk("enc2_out_valid_e32", out_valid_e, 1);
      c2 = data_out_e;
      tick();
      chk("enc2_out_valid_e33", out_valid_e, 0);
      chk("enc2_in_ready_e33", in_ready_e, 1);
      out_ready_e = 1'b0;

      // Back-to-back decrypt: CT then the encrypted PT2
      out_ready_d = 1'b1;
      in_valid_d = 1'b1; data_in_d = CT;
      tick();
      data_in_d = c2;
      for (int k = 1; k <= 34; k++) begin
         tick();
         if (k == 32) begin
            chk("b2b_first_valid", out_valid_d, 1);
            chk("b2b_first_data", data_out_d, PT);
         end
         if (k == 33) begin
            chk("b2b_idle_in_ready", in_ready_d, 1);
            chk("b2b_no_early_accept", busy_d, 0);
         end
      end
      chk("b2b_second_accept_e34", busy_d, 1);
      in_valid_d = 1'b0;
      repeat (31) tick();
      tick();
      chk("b2b_second_valid", out_valid_d, 1);
      chk("b2b_second_data", data_out_d, PT2);
      tick();
      out_ready_d = 1'b0;

      // Garbage on in_valid/data_in while running is ignored
      in_valid_d = 1'b1; data_in_d = CT;
      tick();
      for (int k = 1; k <= 31; k++) begin
         in_valid_d = k[0];
         data_in_d  = {$urandom, $urandom, $urandom, $urandom};
         tick();
         chk("ign_in_ready", in_ready_d, 0);
      end
      in_valid_d = 1'b0;
      tick();
      chk("ign_out_valid", out_valid_d, 1);
      chk("ign_data_out", data_out_d, PT);
      out_ready_d = 1'b1;
      tick();
      out_ready_d = 1'b0;

      // Reset during round 15 aborts the block
      in_valid_d = 1'b1; data_in_d = CT;
      tick();
      in_valid_d = 1'b0;
      repeat (15) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", out_valid_d, 0);
      chk("abort_data_out", data_out_d, 0);
      chk("abort_busy", busy_d, 0);
      chk("abort_in_ready", in_ready_d, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("abort_recover_in_ready", in_ready_d, 1);
      hits = 0;
      out_ready_d = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (out_valid_d) hits++;
      end
      chk("abort_no_result", 128'(hits), 0);
      in_valid_d = 1'b1; data_in_d = CT;
      tick();
      in_valid_d = 1'b0;
      repeat (31) tick();
      tick();
      chk("abort_next_valid", out_valid_d, 1);
      chk("abort_next_data", data_out_d, PT);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
